hdr_collector: RTL and testbench
================================

// Module: hdr_collector
// PURPOSE
//  Upstream stage of the header parser. Collects an 8-bit byte stream (valid/ready/last) into a
//  MAX_LEN-byte header buffer. Zero-pads short packets, discards bytes past MAX_LEN and counts them.
//  Presents the buffer to the parser, issues the one-cycle parser start, then holds the buffer
//  stable until the parser reports ready.
// PARAMETERS
//  MAX_LEN         `HDR_MAX_LEN  header buffer depth in bytes; must match the parser's pkt_hdr_i depth
//  LEN_W           16            width of packet byte counter
//  TIMEOUT_CYCLES  256           watchdog limit in WAIT (only with HDR_COLLECT_TIMEOUT_EN)
// PORTS
//  clk             in   1            clock
//  rst             in   1            reset; asynchronous, active-low
//  in_data_i       in   8            stream byte
//  in_valid_i      in   1            byte valid
//  in_last_i       in   1            last byte of packet; qualified by in_valid_i
//  in_ready_o      out  1            collector accepts a byte this cycle
//  pkt_hdr_o       out  8 x MAX_LEN  header buffer, index 0 = first byte; to parser pkt_hdr_i
//  pkt_len_o       out  LEN_W        total bytes of last collected packet, saturating
//  trunc_o         out  1            last packet was longer than MAX_LEN
//  start_o         out  1            one-cycle pulse to parser start_i
//  mod_busy_i      in   1            parser table-modify in progress (mod_start_i high); start_o held off
//  parser_ready_i  in   1            parser ready_o
//  busy_o          out  1            packet owned by collector/parser (state != IDLE)
//  timeout_o       out  1            watchdog fired, one-cycle pulse (feature only; else tied 0)
// BEHAVIOUR
//  Reset (rst==0, async):
//   - state=IDLE; all buffer bytes 0; pkt_len_o=0, trunc_o=0, start_o=0, timeout_o=0.
//   - in_ready_o=1 once reset releases.
//  A byte is accepted on a clk edge where in_valid_i && in_ready_o. in_ready_o depends only on
//  state; no combinational path from in_valid_i.
//  IDLE:
//   - in_ready_o=1.
//   - On accept: byte[0]<=data; bytes[1..MAX_LEN-1]<=0, same edge; cnt<=1; trunc_o<=0.
//   - Next state: last ? START : FILL.
//  FILL:
//   - in_ready_o=1.
//   - On accept: byte[cnt]<=data; cnt<=cnt+1.
//   - Next state: last ? START : (cnt==MAX_LEN-1 ? DRAIN : FILL).
//  DRAIN:
//   - in_ready_o=1. Accepted bytes are discarded; cnt increments, saturating at 2^LEN_W-1; trunc_o<=1.
//   - last -> START.
//  START:
//   - in_ready_o=0; pkt_len_o<=cnt.
//   - If mod_busy_i==0: start_o=1 this cycle, next state WAIT.
//   - If mod_busy_i==1: start_o=0, stay in START.
//   - start_o is a registered output: it is high exactly in the cycle the FSM occupies START with
//     mod_busy_i low, modeled as a Moore output of a START_GO sub-state.
//  WAIT:
//   - in_ready_o=0. The parser drops ready_o on the edge that samples start, so WAIT ignores
//     parser_ready_i in its first cycle.
//   - From the second cycle on, parser_ready_i==1 -> IDLE.
//  Buffer: pkt_hdr_o changes only on accepted bytes in IDLE/FILL. It is stable from START through
//  the parser's completion.
//  Boundaries:
//   - Packet of exactly MAX_LEN bytes: last on the byte at index MAX_LEN-1 -> START, trunc_o=0.
//   - Single-byte packet (valid&last in IDLE): byte0 stored, rest zero, pkt_len_o=1.
//   - Back-to-back packets: next packet's first byte is accepted the cycle after WAIT->IDLE.
//   - Reset mid-packet: the partial packet is lost; no start_o is emitted.
// CONFIGURATION
//  HDR_COLLECT_TIMEOUT_EN defined:
//   - A counter runs in WAIT.
//   - At TIMEOUT_CYCLES cycles without parser_ready_i: timeout_o=1 for one cycle, state->IDLE.
//     The buffer is kept until the next accept.
//  Not defined: no counter; timeout_o tied 0; WAIT waits indefinitely.
// STRUCTURE
//  def.svh / shared pkg:
//   - state enum {IDLE,FILL,DRAIN,START,WAIT}; HDR_MAX_LEN; BYTE_BUS; TRUE/FALSE.
//   - Add PKT_LEN_BUS (LEN_W-1:0).
//  Single module. The watchdog is inline under the macro; no sub-module is needed.
// TESTING
//  1. 14-byte packet 0x00..0x0D:
//     -> bytes 0..13 match, 14..MAX_LEN-1 are 0; start_o one pulse; pkt_len_o=14; trunc_o=0.
//  2. MAX_LEN+10 byte packet:
//     -> first MAX_LEN bytes stored; in_ready_o stays 1 through DRAIN; pkt_len_o=MAX_LEN+10; trunc_o=1.
//  3. mod_busy_i high for 5 cycles at START:
//     -> start_o delayed until mod_busy_i falls; buffer unchanged; in_ready_o=0.
//  4. Two back-to-back packets with a parser model returning ready 3 cycles after start:
//     -> one start_o per packet; 2nd packet's first byte accepted the cycle after ready.
//  5. rst pulled low mid-FILL (byte 5):
//     -> all outputs reset immediately; no start_o.
//     -> New 1-byte packet then yields pkt_len_o=1 and byte0 only.
//  6. HDR_COLLECT_TIMEOUT_EN, TIMEOUT_CYCLES=8, parser_ready_i stuck 0:
//     -> timeout_o pulse 8 cycles after WAIT entry; state IDLE.

Source files
------------

// File: rtl/hdr_collector_pkg.sv
// Shared types and constants for the header collector: FSM state encoding,
// default header depth and bus widths.
package hdr_collector_pkg;

    localparam int   HDR_MAX_LEN = 32;
    localparam int   BYTE_W      = 8;
    localparam int   PKT_LEN_W   = 16;
    localparam logic TRUE        = 1'b1;
    localparam logic FALSE       = 1'b0;

    typedef logic [BYTE_W-1:0]    byte_bus_t;
    typedef logic [PKT_LEN_W-1:0] pkt_len_bus_t;

    // START_GO is the single cycle in which start_o is presented to the parser.
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        START,
        START_GO,
        WAIT
    } state_t;

endpackage

// File: rtl/hdr_collector.sv
// Collects a byte stream into a MAX_LEN-byte header buffer and hands it to the parser.
// Optional WAIT-state watchdog enabled by defining HDR_COLLECT_TIMEOUT_EN.
module hdr_collector
    import hdr_collector_pkg::*;
#(
    parameter int MAX_LEN        = HDR_MAX_LEN,
    parameter int LEN_W          = PKT_LEN_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  byte_bus_t               in_data_i,
    input  logic                    in_valid_i,
    input  logic                    in_last_i,
    output logic                    in_ready_o,
    output logic [MAX_LEN-1:0][7:0] pkt_hdr_o,
    output logic [LEN_W-1:0]        pkt_len_o,
    output logic                    trunc_o,
    output logic                    start_o,
    input  logic                    mod_busy_i,
    input  logic                    parser_ready_i,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int IDX_W = $clog2(MAX_LEN);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [IDX_W-1:0] wr_idx;
    logic             accept;
    logic             start_nxt;
    logic             wait_first;
    logic             tmo_fire;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    assign in_ready_o = (state == IDLE) || (state == FILL) || (state == DRAIN);
    assign busy_o     = (state != IDLE);
    assign accept     = in_valid_i && in_ready_o;
    assign wr_idx     = cnt[IDX_W-1:0];

`ifdef HDR_COLLECT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;

    // A ready seen in the first WAIT cycle does not count, so it cannot rescue a timeout either.
    assign tmo_fire = (state == WAIT) && (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) &&
                      !(parser_ready_i && !wait_first);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr       <= '0;
            timeout_o <= FALSE;
        end else begin
            timeout_o <= tmo_fire;
            tmr       <= (state == WAIT) ? tmr + TMR_W'(1) : '0;
        end
    end
`else
    assign tmo_fire  = FALSE;
    assign timeout_o = FALSE;
`endif

    always_comb begin
        state_nxt = state;
        start_nxt = FALSE;
        case (state)
            IDLE: begin
                if (accept) state_nxt = in_last_i ? START : FILL;
            end
            FILL: begin
                if (accept) begin
                    if (in_last_i)                        state_nxt = START;
                    else if (cnt == LEN_W'(MAX_LEN - 1))  state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && in_last_i) state_nxt = START;
            end
            START: begin
                if (!mod_busy_i) begin
                    state_nxt = START_GO;
                    start_nxt = TRUE;
                end
            end
            START_GO: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if ((!wait_first && parser_ready_i) || tmo_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wait_first <= FALSE;
            start_o    <= FALSE;
            trunc_o    <= FALSE;
            pkt_len_o  <= '0;
            pkt_hdr_o  <= '0;
        end else begin
            state      <= state_nxt;
            start_o    <= start_nxt;
            wait_first <= (state_nxt == WAIT) && (state != WAIT);
            if (accept) begin
                case (state)
                    IDLE: begin
                        // Clearing the tail here zero-pads short packets without a separate pass.
                        pkt_hdr_o    <= '0;
                        pkt_hdr_o[0] <= in_data_i;
                        cnt          <= LEN_W'(1);
                        trunc_o      <= FALSE;
                    end
                    FILL: begin
                        pkt_hdr_o[wr_idx] <= in_data_i;
                        cnt               <= cnt + LEN_W'(1);
                    end
                    DRAIN: begin
                        cnt     <= sat_inc(cnt);
                        trunc_o <= TRUE;
                    end
                    default: ;
                endcase
            end
            if (state == START) pkt_len_o <= cnt;
        end
    end

endmodule

// File: tb/tb_hdr_collector.sv
// Self-checking bench for hdr_collector: table-driven packets, hand-written corner
// sequences and randomized packets against a packet-level reference model.
module tb_hdr_collector;
    import hdr_collector_pkg::*;

    localparam int ML = HDR_MAX_LEN;
    typedef logic [ML-1:0][7:0] hdr_t;

    typedef struct {
        int len;
        int base;
        int step;
        int busy;
        int exp_len;
        bit exp_trunc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_valid_i = 1'b0;
    logic        in_last_i = 1'b0;
    logic        in_ready_o;
    hdr_t        pkt_hdr_o;
    logic [15:0] pkt_len_o;
    logic        trunc_o;
    logic        start_o;
    logic        mod_busy_i = 1'b0;
    logic        parser_ready_i = 1'b1;
    logic        busy_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    // Parser model controls: latency until ready returns, extra delay before ready drops, stuck.
    int plat   = 3;
    int pdrop  = 0;
    bit pstuck = 1'b0;
    int pk     = -1;

    logic [7:0] pkt_q[$];
    hdr_t       exp_hdr;
    vec_t       tbl[7];

    hdr_collector #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_last_i      (in_last_i),
        .in_ready_o     (in_ready_o),
        .pkt_hdr_o      (pkt_hdr_o),
        .pkt_len_o      (pkt_len_o),
        .trunc_o        (trunc_o),
        .start_o        (start_o),
        .mod_busy_i     (mod_busy_i),
        .parser_ready_i (parser_ready_i),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    // Parser: ready drops pdrop cycles after start is seen and returns plat cycles later.
    always @(negedge clk) begin
        if (start_o) pk = 0;
        else if (pk >= 0) pk++;
        if (pk >= 0 && !pstuck && pk >= pdrop + plat) pk = -1;
        if (pk >= 0 && pstuck && !busy_o) pk = -1;
        parser_ready_i = (pk < 0) || (pk < pdrop);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_hdr(input string name, input hdr_t act, input hdr_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic hdr_t model_hdr();
        hdr_t h = '0;
        for (int i = 0; i < pkt_q.size() && i < ML; i++) h[i] = pkt_q[i];
        return h;
    endfunction

    function automatic int model_len();
        return (pkt_q.size() > 65535) ? 65535 : pkt_q.size();
    endfunction

    // Sends pkt_q; leaves the bench at the first negedge in START after busy cycles of hold-off.
    task automatic drive_pkt(input int busy, input bit gaps);
        int len;
        int g;
        len = pkt_q.size();
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_valid_i = 1'b0;
                    in_last_i  = 1'($urandom_range(0, 1));
                    in_data_i  = 8'($urandom);
                    @(negedge clk);
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = pkt_q[i];
            in_last_i  = (i == len - 1);
            if (i == len - 1) mod_busy_i = (busy > 0);
            chk("ready_in_pkt", int'(in_ready_o), 1);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        chk("ready_at_start", int'(in_ready_o), 0);
        for (int k = 0; k < busy; k++) begin
            chk("held_off", int'(start_o), 0);
            chk("ready_held", int'(in_ready_o), 0);
            chk_hdr("hdr_in_start", pkt_hdr_o, exp_hdr);
            @(negedge clk);
        end
        mod_busy_i = 1'b0;
    endtask

    task automatic wait_start(input int exp_len, input bit exp_trunc);
        int t;
        t = 0;
        while (!start_o && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", int'(start_o), 1);
        chk_hdr("hdr", pkt_hdr_o, exp_hdr);
        chk("pkt_len", int'(pkt_len_o), exp_len);
        chk("trunc", int'(trunc_o), int'(exp_trunc));
    endtask

    // From the start negedge until the collector accepts again; checks when that happens.
    task automatic finish_pkt();
        int c;
        int exp_c;
        c = 0;
        exp_c = ((pdrop + plat) > 2 ? (pdrop + plat) : 2) + 1;
        do begin
            @(negedge clk);
            c++;
            chk("single_start", int'(start_o), 0);
            chk("no_timeout", int'(timeout_o), 0);
            chk_hdr("hdr_stable", pkt_hdr_o, exp_hdr);
        end while (!in_ready_o && c < 100);
        chk("ready_return", c, exp_c);
    endtask

    initial begin
        tbl[0] = '{14,     8'h00, 1, 0, 14,     1'b0};
        tbl[1] = '{ML + 10, 8'h40, 3, 0, ML + 10, 1'b1};
        tbl[2] = '{5,      8'h80, 7, 5, 5,      1'b0};
        tbl[3] = '{ML,     8'h01, 1, 0, ML,     1'b0};
        tbl[4] = '{1,      8'hC3, 0, 0, 1,      1'b0};
        tbl[5] = '{ML + 1, 8'h09, 5, 2, ML + 1, 1'b1};
        tbl[6] = '{ML - 1, 8'hF0, 1, 1, ML - 1, 1'b0};

        repeat (3) @(negedge clk);
        chk_hdr("rst_hdr", pkt_hdr_o, '0);
        chk("rst_len", int'(pkt_len_o), 0);
        chk("rst_trunc", int'(trunc_o), 0);
        chk("rst_start", int'(start_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready_o), 1);

        for (int v = 0; v < 7; v++) begin
            pkt_q.delete();
            for (int i = 0; i < tbl[v].len; i++) pkt_q.push_back(8'(tbl[v].base + i * tbl[v].step));
            exp_hdr = model_hdr();
            drive_pkt(tbl[v].busy, 1'b0);
            wait_start(tbl[v].exp_len, tbl[v].exp_trunc);
            finish_pkt();
        end

        // Back-to-back: next packet's byte waits on the bus through WAIT.
        pkt_q.delete();
        for (int i = 0; i < 6; i++) pkt_q.push_back(8'(8'h20 + i));
        exp_hdr = model_hdr();
        drive_pkt(0, 1'b0);
        wait_start(6, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 8'hA5;
        in_last_i  = 1'b1;
        finish_pkt();
        @(negedge clk);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        pkt_q.delete();
        pkt_q.push_back(8'hA5);
        exp_hdr = model_hdr();
        wait_start(1, 1'b0);
        finish_pkt();

        // Reset in the middle of a packet.
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(8'h11 * (i + 1));
            in_last_i  = 1'b0;
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk_hdr("midrst_hdr", pkt_hdr_o, '0);
        chk("midrst_len", int'(pkt_len_o), 0);
        chk("midrst_trunc", int'(trunc_o), 0);
        chk("midrst_start", int'(start_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        in_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(in_ready_o), 1);
        for (int k = 0; k < 10; k++) begin
            chk("midrst_no_start", int'(start_o), 0);
            @(negedge clk);
        end
        pkt_q.delete();
        pkt_q.push_back(8'h5A);
        exp_hdr = model_hdr();
        drive_pkt(0, 1'b0);
        wait_start(1, 1'b0);
        finish_pkt();

`ifdef HDR_COLLECT_TIMEOUT_EN
        begin
            int c;
            pstuck = 1'b1;
            pkt_q.delete();
            for (int i = 0; i < 3; i++) pkt_q.push_back(8'(8'h70 + i));
            exp_hdr = model_hdr();
            drive_pkt(0, 1'b0);
            wait_start(3, 1'b0);
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!timeout_o && c < 30);
            chk("timeout_at", c, 9);
            chk("timeout_idle", int'(busy_o), 0);
            chk("timeout_ready", int'(in_ready_o), 1);
            @(negedge clk);
            chk("timeout_pulse", int'(timeout_o), 0);
            chk_hdr("timeout_hdr_kept", pkt_hdr_o, exp_hdr);
            pstuck = 1'b0;
            @(negedge clk);
        end
`endif

        for (int p = 0; p < 40; p++) begin
            int len;
            int busy;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(ML - 1, ML + 1);
            else                           len = $urandom_range(1, ML + 20);
            busy  = $urandom_range(0, 3);
            plat  = $urandom_range(1, 5);
            pdrop = ($urandom_range(0, 1) == 1) ? 2 : 0;
            pkt_q.delete();
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
            exp_hdr = model_hdr();
            drive_pkt(busy, 1'b1);
            wait_start(model_len(), pkt_q.size() > ML);
            finish_pkt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
